// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : owns the fetch PC, issues 1-cycle-latency imem reads, queues
//              returned words in order for dispatch, handles redirect and HLT.
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_stall,
    input  logic        in_redirect,
    input  logic [63:0] in_redirect_pc,
    output logic        out_imem_req,
    output logic [63:0] out_imem_addr,
    input  logic [31:0] in_imem_rdata,
    output logic [31:0] out_insnbits,
    output logic [63:0] out_pc,
    output logic        out_fetch_done,
    output logic        out_halted
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [63:0]        inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        insn_mem_q [QUEUE_DEPTH];
    logic [63:0]        pc_mem_q   [QUEUE_DEPTH];

    logic               w_push;
    logic               w_pop;
    logic               w_hlt;
    logic               w_req;
    logic               w_not_empty;
    logic [CNT_W:0]     w_occupancy;

    assign w_not_empty = (count_q != '0);
    assign w_push      = inflight_q && !in_redirect;
    assign w_pop       = w_not_empty && !in_stall && !in_redirect;
    assign w_hlt       = w_push && (in_imem_rdata[31:21] == 11'b110_1010_0010)
                                && (in_imem_rdata[4:0] == 5'b0_0000);

    // Counting the inflight word reserves its slot, so the queue never overflows.
    assign w_occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign w_req       = in_rst_n && (state_q == ST_RUN) && !in_redirect && !w_hlt
                         && (w_occupancy < (CNT_W+1)'(QUEUE_DEPTH));

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = w_req;
        inflight_pc_d = inflight_pc_q;
        if (in_redirect) begin
            state_d    = ST_RUN;
            fetch_pc_d = in_redirect_pc & ~64'h3;
            inflight_d = 1'b0;
        end else begin
            if (w_hlt) begin
                state_d = ST_HALTED;
            end
            if (w_req) begin
                fetch_pc_d    = fetch_pc_q + 64'd4;
                inflight_pc_d = fetch_pc_q;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 64'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (in_redirect) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (w_pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (w_push) begin
            insn_mem_q[tail_q] <= in_imem_rdata;
            pc_mem_q[tail_q]   <= inflight_pc_q;
        end
    end

    assign out_imem_req   = w_req;
    assign out_imem_addr  = in_rst_n ? fetch_pc_q : 64'h0;
    assign out_fetch_done = w_not_empty;
    assign out_insnbits   = w_not_empty ? insn_mem_q[head_q] : 32'h0;
    assign out_pc         = w_not_empty ? pc_mem_q[head_q]   : 64'h0;
    assign out_halted     = (state_q == ST_HALTED) && !w_not_empty && !inflight_q;

endmodule
`default_nettype wire
